// File: rtl/id_ex_if.sv
// id_ex_if: decode-side instruction fields in, registered execute-stage bundle out
interface id_ex_if #(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int CW = 7
);
  logic          id_valid;
  logic [DW-1:0] id_pc;
  logic [DW-1:0] id_regA;
  logic [DW-1:0] id_regB;
  logic [DW-1:0] id_imm;
  logic [CW-1:0] id_ex_ctrl;
  logic [1:0]    id_mem_ctrl;
  logic [1:0]    id_wb_ctrl;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_halt;
  logic          ex_valid;
  logic          ex_halt;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] ex_regA;
  logic [DW-1:0] ex_regB;
  logic [DW-1:0] ex_imm;
  logic [CW-1:0] ex_ex_ctrl;
  logic [1:0]    ex_mem_ctrl;
  logic [1:0]    ex_wb_ctrl;
  logic [RW-1:0] ex_rs;
  logic [RW-1:0] ex_rt;
  logic [RW-1:0] ex_rd;
  modport master (
    input  id_valid, id_pc, id_regA, id_regB, id_imm, id_ex_ctrl, id_mem_ctrl, id_wb_ctrl,
           id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_halt,
    output ex_valid, ex_halt, ex_pc, ex_regA, ex_regB, ex_imm, ex_ex_ctrl, ex_mem_ctrl,
           ex_wb_ctrl, ex_rs, ex_rt, ex_rd
  );
  modport slave (
    output id_valid, id_pc, id_regA, id_regB, id_imm, id_ex_ctrl, id_mem_ctrl, id_wb_ctrl,
           id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_halt,
    input  ex_valid, ex_halt, ex_pc, ex_regA, ex_regB, ex_imm, ex_ex_ctrl, ex_mem_ctrl,
           ex_wb_ctrl, ex_rs, ex_rt, ex_rd
  );
endinterface

// File: rtl/id_ex_issue.sv
// id_ex_issue: ID/EX pipeline register with load-use bubbles, flush, hold and halt drain
module id_ex_issue #(
  parameter int DW  = 16,
  parameter int RW  = 4,
  parameter int CW  = 7,
  parameter int SCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           hold,
  id_ex_if.master        bus,
  output logic           stall_id,
  output logic           halted,
  output logic [SCW-1:0] stall_count
);
  typedef enum logic [1:0] {RUN, HALT_DRAIN, HALTED} state_t;
  state_t        state_q, state_d;
  logic [1:0]    drain_q, drain_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic          valid_q, halt_q;
  logic [DW-1:0] pc_q, a_q, b_q, imm_q;
  logic [CW-1:0] ctrl_q;
  logic [1:0]    mem_q, wb_q;
  logic [RW-1:0] rs_q, rt_q, rd_q;
  logic          run, lu, cap;
  always_comb begin
    run      = state_q == RUN;
    lu       = valid_q & mem_q[1] & (rd_q != '0) & bus.id_valid &
               ((bus.id_use_rs & (bus.id_rs == rd_q)) | (bus.id_use_rt & (bus.id_rt == rd_q)));
    cap      = run & ~hold & ~flush & ~lu & bus.id_valid;
    stall_id = hold | ~run | (~flush & lu);
    state_d  = hold ? state_q :
               (cap & bus.id_halt) ? HALT_DRAIN :
               (state_q == HALT_DRAIN && drain_q == 2'd2) ? HALTED : state_q;
    drain_d  = (state_q == HALT_DRAIN && !hold) ? drain_q + 2'd1 : drain_q;
    cnt_d    = (run & ~hold & ~flush & lu & ~&cnt_q) ? cnt_q + SCW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
      if (!hold) begin
        valid_q <= cap;
        halt_q  <= cap & bus.id_halt;
        pc_q    <= cap ? bus.id_pc : '0;
        a_q     <= cap ? bus.id_regA : '0;
        b_q     <= cap ? bus.id_regB : '0;
        imm_q   <= cap ? bus.id_imm : '0;
        ctrl_q  <= cap ? bus.id_ex_ctrl : '0;
        mem_q   <= cap ? bus.id_mem_ctrl : '0;
        wb_q    <= cap ? bus.id_wb_ctrl : '0;
        rs_q    <= cap ? bus.id_rs : '0;
        rt_q    <= cap ? bus.id_rt : '0;
        rd_q    <= cap ? bus.id_rd : '0;
      end
    end
  end
  assign bus.ex_valid    = valid_q;
  assign bus.ex_halt     = halt_q;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_regA     = a_q;
  assign bus.ex_regB     = b_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_ex_ctrl  = ctrl_q;
  assign bus.ex_mem_ctrl = mem_q;
  assign bus.ex_wb_ctrl  = wb_q;
  assign bus.ex_rs       = rs_q;
  assign bus.ex_rt       = rt_q;
  assign bus.ex_rd       = rd_q;
  assign halted          = state_q == HALTED;
  assign stall_count     = cnt_q;
endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
- Producer side of the execute-stage operand interface: the ID/EX pipeline register that delivers pc, register operands, immediate and the 7-bit EX control bundle to the execute stage each cycle.
- Owns load-use hazard detection, bubble insertion, branch flush, downstream hold and halt sequencing.
- Sits between the decode stage and the execute stage of the 16-bit pipelined CPU.

Parameters:
- DW, 16, datapath width (pc, operands, immediate)
- RW, 4, register-specifier width (16 architectural registers, R0 reads as zero)
- CW, 7, EX control bundle width
- SCW, 16, load-use stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode stage presents a real instruction
- id_pc  in  DW  pc of the decode instruction
- id_regA, id_regB  in  DW  register-file read data
- id_imm  in  DW  sign/zero-extended immediate
- id_ex_ctrl  in  CW  EX controls: ALU source select and ALU opcode
- id_mem_ctrl  in  2  {memRead, memWrite}
- id_wb_ctrl  in  2  {regWrite, memToReg}
- id_rs, id_rt, id_rd  in  RW  source and destination specifiers
- id_use_rs, id_use_rt  in  1  instruction actually reads rs / rt
- id_halt  in  1  decode instruction is HLT
- flush  in  1  branch resolved taken; squash the decode instruction
- hold  in  1  downstream stall; freeze this register
- ex_valid, ex_halt  out  1  registered
- ex_pc, ex_regA, ex_regB, ex_imm  out  DW  registered
- ex_ex_ctrl  out  CW  registered
- ex_mem_ctrl, ex_wb_ctrl  out  2  registered
- ex_rs, ex_rt, ex_rd  out  RW  registered
- stall_id  out  1  combinational; freeze PC and IF/ID this cycle
- halted  out  1  registered; pipeline has drained the halt
- stall_count  out  SCW  registered; saturating load-use bubble count

Behaviour:
- Reset: every registered output is 0, state is RUN, and stall_count is 0. Reset applies mid-operation with top priority.
- Bubble definition: ex_valid=0, ex_ex_ctrl=0, ex_mem_ctrl=0, ex_wb_ctrl=0, ex_halt=0. Data fields are don't-care; the RTL drives them to 0.
- Load-use condition (lu), combinational:
  - ex_valid & ex_mem_ctrl[1] & ex_rd!=0 & id_valid
  - & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd))
- State RUN, per-cycle priority:
  1. hold=1: all registers keep their value; stall_id=1; stall_count unchanged.
  2. flush=1: load a bubble; stall_id=0. Flush wins over lu.
  3. lu=1: load a bubble; stall_id=1; stall_count+=1, saturating at all-ones. Exactly one bubble per load: the next cycle the load is in MEM, so lu is false.
  4. id_valid=1: capture all id_* fields; ex_valid=1. If id_halt=1, go to HALT_DRAIN.
  5. Otherwise load a bubble.
- State HALT_DRAIN:
  - stall_id=1 constantly; bubbles loaded every non-held cycle.
  - A 2-bit drain counter counts the non-held cycles the halt takes to pass through MEM and WB.
  - After 3 non-held cycles, go to HALTED.
  - flush=1 in HALT_DRAIN: ignored, because the halt is older than any branch behind it.
- State HALTED:
  - halted=1, stall_id=1, bubbles only; exited only by rst.
- Latency: a captured instruction appears on ex_* one cycle after its id_* inputs.
- stall_id depends only on current registered state and the id_* and flush/hold inputs; there is no path from ex_* feedback within the same edge.

Test Plan:
- Reset mid-stream: ex_valid=1, ex_pc=0x0042, then rst=1 for 1 cycle -> next cycle every output is 0, state RUN, stall_count=0.
- Load-use: EX holds a load with rd=3; ID presents ADD with rs=3, id_use_rs=1 -> stall_id=1 that cycle, then a bubble on ex_*, stall_count=1. Next cycle the ADD is captured with ex_pc equal to its id_pc.
- Load-use boundaries:
  - Same load but rd=0 -> no stall.
  - rs=3 with id_use_rs=0 -> no stall.
  - Load with rd=5 while ID rt=5, id_use_rt=1 -> stall.
- Flush vs lu: flush=1 and lu=1 in the same cycle -> bubble, stall_id=0, stall_count unchanged.
- Hold: hold=1 for 3 cycles while ex_pc=0x0010, ex_regA=0xBEEF -> outputs unchanged for all 3 cycles, stall_id=1; release -> normal capture.
- Halt and saturation:
  - HLT at pc=0x0020 -> ex_halt=1 for one cycle, then bubbles, with halted=1 exactly 3 non-held cycles later.
  - A flush issued during the drain is ignored.
  - With SCW=2, 5 load-use stalls -> stall_count=3.
